alu_issue_ctrl: RTL and testbench

Multi-cycle sequencer that drives the datapath ALU. It accepts one 16-bit instruction word over a valid/ready handshake and reads the operands from the external register file. It then presents the operands and opcode to the ALU, captures the ALU result and flags, and writes the result back. It also holds the processor status register (PSR) that the branch and condition logic consume.

---
 rtl/alu_issue_ctrl_pkg.sv | 28 ++
 rtl/alu_issue_ctrl_decode.sv | 41 ++++
 rtl/alu_issue_ctrl.sv | 149 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared ALU opcode encodings, PSR bit indices and sequencer state codes.
// Imported by the issue controller and its field decoder.
package alu_issue_ctrl_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_CMP  = 4'h2;
    localparam logic [3:0] OP_TEST = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_LSH  = 4'h8;
    localparam logic [3:0] OP_RSH  = 4'h9;
    localparam logic [3:0] OP_ARSH = 4'hA;

    localparam int PSR_C = 0;
    localparam int PSR_L = 1;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 3;
    localparam int PSR_N = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational split of a 16-bit instruction word into its fields.
// Ports: instr in; opcode, rd, rs, imm_en, imm, is_legal, writes_back out.
module instr_field_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [15:0] instr,
    output logic [3:0]  opcode,
    output logic [3:0]  rd,
    output logic [3:0]  rs,
    output logic        imm_en,
    output logic [6:0]  imm,
    output logic        is_legal,
    output logic        writes_back
);

    assign opcode = instr[15:12];
    assign rd     = instr[11:8];
    assign imm_en = instr[7];
    assign imm    = instr[6:0];
    // The immediate overlays rs, so the B read port is parked on r0.
    assign rs     = instr[7] ? 4'h0 : instr[3:0];

    always_comb begin
        is_legal    = 1'b0;
        writes_back = 1'b0;
        unique case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_NOT, OP_LSH, OP_RSH, OP_ARSH: begin
                is_legal    = 1'b1;
                writes_back = 1'b1;
            end
            OP_CMP, OP_TEST: begin
                is_legal = 1'b1;
            end
            default: begin
                is_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Four-state issue sequencer (IDLE/READ/EXEC/WB) driving the datapath ALU.
// Ports: instr handshake, RF read/write, ALU operands/flags, psr, done, illegal.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int IMM_W  = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    output logic [REG_AW-1:0] rf_raddr_a,
    output logic [REG_AW-1:0] rf_raddr_b,
    input  logic [DATA_W-1:0] rf_rdata_a,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_opcode,
    output logic              alu_carry_in,
    input  logic [DATA_W-1:0] alu_c,
    input  logic              alu_carry,
    input  logic              alu_flag,
    input  logic              alu_low,
    input  logic              alu_negative,
    input  logic              alu_zero,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [4:0]        psr,
    output logic              done,
    output logic              illegal
);

    logic [1:0]        state;
    logic [3:0]        op_q;
    logic [REG_AW-1:0] rd_q;
    logic              imm_en_q;
    logic [IMM_W-1:0]  imm_q;
    logic              legal_q;
    logic              wb_q;
    logic [3:0]        alu_op_q;
    logic [DATA_W-1:0] result_q;

    logic [3:0] d_opcode;
    logic [3:0] d_rd;
    logic [3:0] d_rs;
    logic       d_imm_en;
    logic [6:0] d_imm;
    logic       d_legal;
    logic       d_wb;

    logic [DATA_W-1:0] imm_sx;

    instr_field_decode u_dec (
        .instr       (instr),
        .opcode      (d_opcode),
        .rd          (d_rd),
        .rs          (d_rs),
        .imm_en      (d_imm_en),
        .imm         (d_imm),
        .is_legal    (d_legal),
        .writes_back (d_wb)
    );

    assign imm_sx = {{(DATA_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};

    assign instr_ready  = (state == S_IDLE);
    assign alu_carry_in = psr[PSR_C];
    assign alu_opcode   = alu_op_q;
    assign rf_waddr     = rd_q;
    assign rf_wdata     = result_q;

    // Operands are only presented while the ALU is being used.
    always_comb begin
        alu_a = '0;
        alu_b = '0;
        if (state == S_EXEC) begin
            alu_a = rf_rdata_a;
            alu_b = imm_en_q ? imm_sx : rf_rdata_b;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            op_q       <= '0;
            rd_q       <= '0;
            imm_en_q   <= 1'b0;
            imm_q      <= '0;
            legal_q    <= 1'b0;
            wb_q       <= 1'b0;
            alu_op_q   <= '0;
            result_q   <= '0;
            rf_raddr_a <= '0;
            rf_raddr_b <= '0;
            psr        <= '0;
            rf_we      <= 1'b0;
            done       <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            rf_we   <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        op_q       <= d_opcode;
                        rd_q       <= d_rd;
                        imm_en_q   <= d_imm_en;
                        imm_q      <= d_imm;
                        legal_q    <= d_legal;
                        wb_q       <= d_wb;
                        rf_raddr_a <= d_rd;
                        rf_raddr_b <= d_rs;
                        state      <= S_READ;
                    end
                end
                S_READ: begin
                    // An illegal opcode leaves the ALU opcode untouched.
                    if (legal_q) begin
                        alu_op_q <= op_q;
                    end
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (legal_q) begin
                        result_q <= alu_c;
                        psr      <= {alu_negative, alu_zero, alu_flag,
                                     alu_low, alu_carry};
                    end
                    rf_we   <= legal_q & wb_q;
                    done    <= 1'b1;
                    illegal <= ~legal_q;
                    state   <= S_WB;
                end
                S_WB: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl.
// Provides a registered-read register file and a small ALU model.
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [3:0]  rf_raddr_a;
    logic [3:0]  rf_raddr_b;
    logic [15:0] rf_rdata_a;
    logic [15:0] rf_rdata_b;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_opcode;
    logic        alu_carry_in;
    logic [15:0] alu_c;
    logic        alu_carry;
    logic        alu_flag;
    logic        alu_low;
    logic        alu_negative;
    logic        alu_zero;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [4:0]  psr;
    logic        done;
    logic        illegal;

    int pass_cnt = 0;
    int total    = 0;

    logic        force_flags;
    logic        pre_we;
    logic [3:0]  pre_addr;
    logic [15:0] pre_data;
    logic [15:0] rf [16];
    logic [16:0] sum17;

    alu_issue_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_ready  (instr_ready),
        .rf_raddr_a   (rf_raddr_a),
        .rf_raddr_b   (rf_raddr_b),
        .rf_rdata_a   (rf_rdata_a),
        .rf_rdata_b   (rf_rdata_b),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_opcode   (alu_opcode),
        .alu_carry_in (alu_carry_in),
        .alu_c        (alu_c),
        .alu_carry    (alu_carry),
        .alu_flag     (alu_flag),
        .alu_low      (alu_low),
        .alu_negative (alu_negative),
        .alu_zero     (alu_zero),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .psr          (psr),
        .done         (done),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rf_rdata_a <= rf[rf_raddr_a];
        rf_rdata_b <= rf[rf_raddr_b];
        if (rf_we) rf[rf_waddr] <= rf_wdata;
        if (pre_we) rf[pre_addr] <= pre_data;
    end

    always_comb begin
        sum17        = '0;
        alu_c        = '0;
        alu_carry    = 1'b0;
        alu_flag     = 1'b0;
        alu_low      = 1'b0;
        case (alu_opcode)
            OP_ADD: begin
                sum17     = {1'b0, alu_a} + {1'b0, alu_b};
                alu_c     = sum17[15:0];
                alu_carry = sum17[16];
                alu_flag  = (alu_a[15] == alu_b[15]) &&
                            (alu_c[15] != alu_a[15]);
            end
            OP_SUB, OP_CMP: begin
                alu_c     = alu_a - alu_b;
                alu_carry = alu_a < alu_b;
                alu_low   = alu_a < alu_b;
                alu_flag  = (alu_a[15] != alu_b[15]) &&
                            (alu_c[15] != alu_a[15]);
            end
            OP_AND, OP_TEST: alu_c = alu_a & alu_b;
            OP_OR:           alu_c = alu_a | alu_b;
            OP_XOR:          alu_c = alu_a ^ alu_b;
            OP_NOT:          alu_c = ~alu_a;
            default:         alu_c = '0;
        endcase
        alu_negative = alu_c[15];
        alu_zero     = (alu_c == 16'h0000);
        if (force_flags) begin
            alu_carry    = 1'b1;
            alu_flag     = 1'b1;
            alu_low      = 1'b1;
            alu_negative = 1'b1;
            alu_zero     = 1'b1;
        end
    end

    function automatic logic [15:0] enc(input logic [3:0] op,
                                        input logic [3:0] rd,
                                        input logic       ie,
                                        input logic [6:0] lo);
        return {op, rd, ie, lo};
    endfunction

    task automatic rf_load(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // Presents one word; returns #1 after the accept edge (READ cycle).
    task automatic issue(input logic [15:0] w);
        int n;
        n = 0;
        @(negedge clk);
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (instr_ready !== 1'b1)
            $display("FAIL issue_ready: got %b want 1", instr_ready);
        else
            pass_cnt++;
        instr_valid = 1'b1;
        instr       = w;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = 16'hA5FF;
    endtask

    task automatic test_reset;
        reset_n     = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        force_flags = 1'b0;
        pre_we      = 1'b0;
        pre_addr    = '0;
        pre_data    = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({rf_we, done, illegal} !== 3'b000)
            $display("FAIL rst_strobes: got %b want 000",
                     {rf_we, done, illegal});
        else pass_cnt++;
        total++;
        if (psr !== 5'h00)
            $display("FAIL rst_psr: got %h want 00", psr);
        else pass_cnt++;
        total++;
        if ({rf_raddr_a, rf_raddr_b, rf_waddr} !== 12'h000)
            $display("FAIL rst_addr: got %h want 000",
                     {rf_raddr_a, rf_raddr_b, rf_waddr});
        else pass_cnt++;
        total++;
        if ({rf_wdata, alu_a, alu_b, alu_opcode} !== 52'h0)
            $display("FAIL rst_data: got %h want 0",
                     {rf_wdata, alu_a, alu_b, alu_opcode});
        else pass_cnt++;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (instr_ready !== 1'b1)
            $display("FAIL rst_ready: got %b want 1", instr_ready);
        else pass_cnt++;
    endtask

    task automatic test_add;
        rf_load(4'd1, 16'h7FFF);
        rf_load(4'd2, 16'h0001);
        issue(enc(OP_ADD, 4'd1, 1'b0, 7'd2));
        @(negedge clk);
        total++;
        if ({instr_ready, rf_raddr_a, rf_raddr_b, rf_we} !== {1'b0, 4'd1, 4'd2, 1'b0})
            $display("FAIL add_read: got %b/%h/%h/%b want 0/1/2/0",
                     instr_ready, rf_raddr_a, rf_raddr_b, rf_we);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if ({alu_a, alu_b, alu_opcode} !== {16'h7FFF, 16'h0001, OP_ADD})
            $display("FAIL add_exec: got %h/%h/%h want 7fff/0001/%h",
                     alu_a, alu_b, alu_opcode, OP_ADD);
        else pass_cnt++;
        total++;
        if (rf_we !== 1'b0)
            $display("FAIL add_exec_we: got %b want 0", rf_we);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if ({rf_we, done, illegal, rf_waddr, rf_wdata} !== {3'b110, 4'd1, 16'h8000})
            $display("FAIL add_wb: got %b%b%b/%h/%h want 110/1/8000",
                     rf_we, done, illegal, rf_waddr, rf_wdata);
        else pass_cnt++;
        total++;
        if (psr !== 5'b10100)
            $display("FAIL add_psr: got %b want 10100", psr);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if ({rf_we, done, instr_ready} !== 3'b001 || rf[1] !== 16'h8000)
            $display("FAIL add_idle: got %b%b%b r1=%h want 001 r1=8000",
                     rf_we, done, instr_ready, rf[1]);
        else pass_cnt++;
    endtask

    task automatic test_sub_imm;
        rf_load(4'd5, 16'h0010);
        issue(enc(OP_SUB, 4'd5, 1'b1, 7'h7F));
        @(negedge clk);
        total++;
        if ({rf_raddr_a, rf_raddr_b} !== {4'd5, 4'd0})
            $display("FAIL sub_read: got %h/%h want 5/0",
                     rf_raddr_a, rf_raddr_b);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if ({alu_a, alu_b} !== {16'h0010, 16'hFFFF})
            $display("FAIL sub_exec: got %h/%h want 0010/ffff", alu_a, alu_b);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if ({rf_we, done, rf_waddr, rf_wdata} !== {2'b11, 4'd5, 16'h0011})
            $display("FAIL sub_wb: got %b%b/%h/%h want 11/5/0011",
                     rf_we, done, rf_waddr, rf_wdata);
        else pass_cnt++;
        total++;
        if (psr !== 5'b00011)
            $display("FAIL sub_psr: got %b want 00011", psr);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (alu_carry_in !== 1'b1)
            $display("FAIL sub_cin: got %b want 1", alu_carry_in);
        else pass_cnt++;
    endtask

    task automatic test_cmp;
        rf_load(4'd3, 16'h0005);
        rf_load(4'd4, 16'h0005);
        issue(enc(OP_CMP, 4'd3, 1'b0, 7'd4));
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({rf_we, done, illegal} !== 3'b010)
            $display("FAIL cmp_wb: got %b%b%b want 010", rf_we, done, illegal);
        else pass_cnt++;
        total++;
        if (psr !== 5'b01000)
            $display("FAIL cmp_psr: got %b want 01000", psr);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (rf[3] !== 16'h0005)
            $display("FAIL cmp_r3: got %h want 0005", rf[3]);
        else pass_cnt++;
    endtask

    task automatic test_illegal;
        rf_load(4'd6, 16'h0001);
        rf_load(4'd7, 16'h0002);
        force_flags = 1'b1;
        issue(enc(OP_ADD, 4'd6, 1'b0, 7'd7));
        repeat (3) @(negedge clk);
        force_flags = 1'b0;
        total++;
        if (psr !== 5'h1F)
            $display("FAIL ill_preload: got %h want 1f", psr);
        else pass_cnt++;
        issue(enc(4'hC, 4'd9, 1'b0, 7'd1));
        @(negedge clk);
        @(negedge clk);
        total++;
        if (alu_opcode !== OP_ADD)
            $display("FAIL ill_exec_op: got %h want %h", alu_opcode, OP_ADD);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if ({rf_we, done, illegal} !== 3'b011)
            $display("FAIL ill_wb: got %b%b%b want 011", rf_we, done, illegal);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (psr !== 5'h1F || illegal !== 1'b0)
            $display("FAIL ill_psr: got %h/%b want 1f/0", psr, illegal);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] rdy;
        logic [7:0] dn;
        logic [7:0] we;
        rf_load(4'd2, 16'h0001);
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = enc(OP_ADD, 4'd1, 1'b0, 7'd2);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            rdy[k] = instr_ready;
            dn[k]  = done;
            we[k]  = rf_we;
            if (k == 7) instr_valid = 1'b0;
        end
        total++;
        if (rdy !== 8'b1000_1000)
            $display("FAIL b2b_ready: got %b want 10001000", rdy);
        else pass_cnt++;
        total++;
        if (dn !== 8'b0100_0100 || we !== 8'b0100_0100)
            $display("FAIL b2b_done: got %b/%b want 01000100", dn, we);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (rf[1] !== 16'h8002)
            $display("FAIL b2b_r1: got %h want 8002", rf[1]);
        else pass_cnt++;
    endtask

    task automatic test_reset_abort;
        int seen;
        rf_load(4'd8, 16'h0100);
        rf_load(4'd9, 16'h0200);
        issue(enc(OP_ADD, 4'd8, 1'b0, 7'd9));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++;
        if ({psr, rf_we, done} !== 7'b0)
            $display("FAIL abort_rst: got %b/%b%b want 00000/00",
                     psr, rf_we, done);
        else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (instr_ready !== 1'b1)
            $display("FAIL abort_ready: got %b want 1", instr_ready);
        else pass_cnt++;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (rf_we || done) seen++;
        end
        total++;
        if (seen != 0 || rf[8] !== 16'h0100 || psr !== 5'h00)
            $display("FAIL abort_nowb: got %0d/%h/%h want 0/0100/00",
                     seen, rf[8], psr);
        else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add();
        test_sub_imm();
        test_cmp();
        test_illegal();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
